// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START / WRITE / READ / STOP commands, quarter-phase SCL generator,
// target clock-stretch support and an out/oe SDA pad pair.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl_out,
  input  logic       scl_in,
  output logic       sda_out,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int unsigned     DivW    = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [1:0] OpStart = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpRead  = 2'd2;
  localparam logic [1:0] OpStop  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StStart,
    StXfer,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      phase_q, phase_d;
  logic [3:0]      bit_q, bit_d;
  logic [8:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            read_q, read_d;
  logic            nack_q, nack_d;
  logic            scl_q, scl_d;
  logic            oe_q, oe_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_nack_q, rsp_nack_d;
  logic            rsp_err_q, rsp_err_d;

  logic stretch;
  logic phase_end;
  logic active;

  // SDA enable for bit idx of a byte: data bits 0-7, acknowledge slot at bit 8.
  function automatic logic bit_oe(input logic is_read, input logic [7:0] data,
                                  input logic nack, input logic [3:0] idx);
    if (idx[3]) return is_read ? ~nack : 1'b0;
    return is_read ? 1'b0 : ~data[3'd7 - idx[2:0]];
  endfunction

  assign active    = (state_q == StStart) || (state_q == StXfer) || (state_q == StStop);
  // A target holding SCL low while we release it freezes the high quarter-phase.
  assign stretch   = active && (phase_q == 2'd1) && scl_q && !scl_in;
  assign phase_end = active && !stretch && (div_q == DivLast);

  always_comb begin
    state_d     = state_q;
    div_d       = '0;
    phase_d     = phase_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    read_d      = read_q;
    nack_d      = nack_q;
    scl_d       = scl_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;
    rsp_err_d   = rsp_err_q;

    if (active && !stretch && !phase_end) begin
      div_d = div_q + 1'b1;
    end
    if (phase_end) begin
      phase_d = phase_q + 2'd1;
    end

    unique case (state_q)
      StIdle, StHold: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          read_d  = (cmd_op == OpRead);
          nack_d  = cmd_nack;
          phase_d = 2'd0;
          bit_d   = 4'd0;
          if (state_q == StIdle && cmd_op != OpStart) begin
            // Byte or STOP without owning the bus: reject, leave pads alone.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_nack_d  = 1'b0;
          end else begin
            unique case (cmd_op)
              OpStart: begin
                state_d = StStart;
                oe_d    = 1'b0;
              end
              OpWrite, OpRead: begin
                state_d = StXfer;
                shift_d = '0;
                scl_d   = 1'b0;
                oe_d    = bit_oe(cmd_op == OpRead, cmd_data, cmd_nack, 4'd0);
              end
              OpStop: begin
                state_d = StStop;
                scl_d   = 1'b0;
                oe_d    = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      StStart: begin
        if (phase_end) begin
          case (phase_q)
            2'd0: scl_d = 1'b1;
            2'd1: oe_d = 1'b1;
            2'd2: scl_d = 1'b0;
            default: state_d = StHold;
          endcase
        end
      end

      StXfer: begin
        if (phase_end) begin
          case (phase_q)
            2'd0: scl_d = 1'b1;
            2'd1: ;
            2'd2: begin
              scl_d   = 1'b0;
              shift_d = {shift_q[7:0], sda_in};
            end
            default: begin
              if (bit_q == 4'd8) begin
                state_d     = StHold;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_nack_d  = shift_q[0];
                rsp_data_d  = read_q ? shift_q[8:1] : 8'h00;
              end else begin
                bit_d = bit_q + 4'd1;
                oe_d  = bit_oe(read_q, data_q, nack_q, bit_q + 4'd1);
              end
            end
          endcase
        end
      end

      StStop: begin
        if (phase_end) begin
          case (phase_q)
            2'd0: scl_d = 1'b1;
            2'd1: oe_d = 1'b0;
            2'd2: ;
            default: state_d = StIdle;
          endcase
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      phase_q     <= 2'd0;
      bit_q       <= 4'd0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      read_q      <= 1'b0;
      nack_q      <= 1'b0;
      scl_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      read_q      <= read_d;
      nack_q      <= nack_d;
      scl_q       <= scl_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle) || (state_q == StHold);
  assign busy      = active;
  assign scl_out   = scl_q;
  assign sda_oe    = oe_q;
  assign sda_out   = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl at CLK_DIV=4 with a simple bit-level I2C target model.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_err;
  logic       busy;
  logic       scl_out;
  logic       scl_in;
  logic       sda_out;
  logic       sda_oe;
  logic       sda_in;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // Target model: bits are indexed by SCL falling edges since the byte was issued.
  int         fall_cnt = 0;
  int         tgt_base = 0;
  int         tidx;
  logic [8:0] tgt_vec  = '1;
  logic       tgt_pull;
  logic       stretch  = 1'b0;
  logic       scl_prev = 1'b1;
  logic [8:0] oe_log   = '0;

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_nack  (cmd_nack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .scl_out   (scl_out),
    .scl_in    (scl_in),
    .sda_out   (sda_out),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in)
  );

  always #5 clk = ~clk;

  always_comb begin
    tgt_pull = 1'b0;
    tidx     = fall_cnt - tgt_base;
    if (tidx >= 0 && tidx <= 8) tgt_pull = !tgt_vec[8 - tidx];
  end

  assign sda_in = !(sda_oe || tgt_pull);
  assign scl_in = scl_out && !stretch;

  // Log the master's SDA enable at each SCL rise: one entry per bit on the bus.
  always @(posedge clk) begin
    scl_prev <= scl_out;
    if (scl_prev === 1'b1 && scl_out === 1'b0) fall_cnt <= fall_cnt + 1;
    if (scl_prev === 1'b0 && scl_out === 1'b1) oe_log <= {oe_log[7:0], sda_oe};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic nk);
    check("ready_before_issue", cmd_ready, 1);
    cmd_op    = op;
    cmd_data  = d;
    cmd_nack  = nk;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cyc       = 1;
  endtask

  task automatic wait_rsp();
    while (!rsp_valid && cyc < 3000) step();
  endtask

  task automatic wait_ready();
    while (!cmd_ready && cyc < 3000) step();
  endtask

  task automatic arm_target(input logic [8:0] v);
    tgt_vec  = v;
    tgt_base = fall_cnt;
  endtask

  initial begin
    int   rises;
    logic prev;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", {scl_out, sda_oe, sda_out, cmd_ready, busy, rsp_valid, rsp_nack,
                            rsp_err, rsp_data}, {8'b1001_0000, 8'h00});

    // WRITE while the bus is free is rejected without touching the pads.
    issue(2'd1, 8'h55, 1'b0);
    check("err_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 8'h00});
    check("err_pads", {scl_out, sda_oe, busy, cmd_ready}, 4'b1001);
    step();
    check("err_pulse_held", {rsp_valid, rsp_err}, 2'b01);

    issue(2'd0, 8'h00, 1'b0);
    check("start_busy", {busy, cmd_ready}, 2'b10);
    wait_ready();
    check("start_len", cyc, 17);
    check("start_hold_pads", {scl_out, sda_oe, busy}, 3'b010);

    // WRITE 0x84, target ACKs.
    arm_target(9'b1_1111_1110);
    issue(2'd1, 8'h84, 1'b0);
    wait_rsp();
    check("wr_rsp_cycle", cyc, 145);
    check("wr_rsp", {rsp_err, rsp_nack, rsp_data}, {2'b00, 8'h00});
    check("wr_sda_bits", oe_log, {~8'h84, 1'b0});

    // STOP issued back-to-back in the response cycle.
    issue(2'd3, 8'h00, 1'b0);
    check("stop_busy", busy, 1);
    wait_ready();
    check("stop_len", cyc, 17);
    check("stop_end_pads", {scl_out, sda_oe, busy}, 3'b100);

    // WRITE 0x3C, target NACKs.
    issue(2'd0, 8'h00, 1'b0);
    wait_ready();
    arm_target(9'h1FF);
    issue(2'd1, 8'h3C, 1'b0);
    wait_rsp();
    check("nack_rsp", {rsp_err, rsp_nack, rsp_data}, {2'b01, 8'h00});
    check("nack_sda_bits", oe_log, {~8'h3C, 1'b0});
    step();
    check("nack_hold", {rsp_valid, cmd_ready, scl_out, busy, rsp_nack}, 5'b01001);

    // READ 0xA5, master NACKs.
    arm_target({8'hA5, 1'b1});
    issue(2'd2, 8'h00, 1'b1);
    wait_rsp();
    check("rd1_rsp_cycle", cyc, 145);
    check("rd1_rsp", {rsp_err, rsp_nack, rsp_data}, {2'b01, 8'hA5});
    check("rd1_sda_bits", oe_log, 9'h000);

    // READ 0xA5, master ACKs.
    arm_target({8'hA5, 1'b1});
    issue(2'd2, 8'h00, 1'b0);
    wait_rsp();
    check("rd0_rsp", {rsp_err, rsp_nack, rsp_data}, {2'b00, 8'hA5});
    check("rd0_sda_bits", oe_log, 9'h001);
    check("rd0_hold_sda", {scl_out, sda_oe}, 2'b01);

    // Repeated start from HOLD with SDA still held low.
    issue(2'd0, 8'h00, 1'b0);
    check("rs_q0_first", {scl_out, sda_oe}, 2'b00);
    repeat (3) step();
    check("rs_q0_last", {scl_out, sda_oe}, 2'b00);
    step();
    check("rs_q1", {scl_out, sda_oe}, 2'b10);
    repeat (4) step();
    check("rs_q2", {scl_out, sda_oe}, 2'b11);
    repeat (4) step();
    check("rs_q3", {scl_out, sda_oe}, 2'b01);
    repeat (3) step();
    check("rs_busy_last", {cyc[7:0], busy}, {8'd16, 1'b1});
    step();
    check("rs_done", {busy, cmd_ready}, 2'b01);

    // READ with the target stretching SCL for 50 cycles in bit 3 q1.
    arm_target({8'hA5, 1'b1});
    issue(2'd2, 8'h00, 1'b1);
    rises = 0;
    prev  = scl_out;
    while (rises < 4 && cyc < 400) begin
      step();
      if (scl_out && !prev) rises++;
      prev = scl_out;
    end
    check("str_bit3_q1_cycle", cyc, 53);
    stretch = 1'b1;
    repeat (50) step();
    check("str_scl_held_high", scl_out, 1);
    stretch = 1'b0;
    wait_rsp();
    check("str_rsp_cycle", cyc, 195);
    check("str_rsp", {rsp_err, rsp_nack, rsp_data}, {2'b01, 8'hA5});

    // Reset in the middle of a byte.
    arm_target(9'h1FF);
    issue(2'd1, 8'h00, 1'b0);
    repeat (45) step();
    check("mid_byte_pads", {scl_out, sda_oe, busy}, 3'b011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_pads", {scl_out, sda_oe, cmd_ready, busy, rsp_valid}, 5'b10100);
    seen = 1'b0;
    repeat (200) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_no_rsp", {seen, scl_out, sda_oe, busy}, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
